// File: rtl/riscv_enc_pkg.sv
// Shared RV32I encoding definitions: format codes, opcodes, immediate ranges
// and the per-format field scatter functions used by the encoder.
package riscv_enc_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [31:0] NOP = 32'h00000013;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam int IMM_I_MIN = -2048;
    localparam int IMM_I_MAX = 2047;
    localparam int IMM_S_MIN = -2048;
    localparam int IMM_S_MAX = 2047;
    localparam int IMM_B_MIN = -4096;
    localparam int IMM_B_MAX = 4094;
    localparam int IMM_J_MIN = -1048576;
    localparam int IMM_J_MAX = 1048574;

    typedef struct packed {
        logic        err;
        logic [31:0] word;
    } enc_beat_t;

    localparam int BEAT_W = $bits(enc_beat_t);

    function automatic logic imm_in_range(input logic [31:0] imm, input int lo, input int hi);
        return ($signed(imm) >= lo) && ($signed(imm) <= hi);
    endfunction

    function automatic logic [31:0] pack_r(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] pack_i(input logic [31:0] imm, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [4:0] rd,
                                           input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] pack_s(input logic [31:0] imm, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [6:0] op);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
    endfunction

    // Branch offsets are halfword-aligned, so imm[0] has no slot in the word.
    function automatic logic [31:0] pack_b(input logic [31:0] imm, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [6:0] op);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
    endfunction

    function automatic logic [31:0] pack_u(input logic [31:0] imm, input logic [4:0] rd,
                                           input logic [6:0] op);
        return {imm[31:12], rd, op};
    endfunction

    function automatic logic [31:0] pack_j(input logic [31:0] imm, input logic [4:0] rd,
                                           input logic [6:0] op);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
    endfunction

endpackage

// File: rtl/enc_pipe_reg.sv
// One valid/ready register slice carrying an encoded word plus its error flag.
// A beat transfers on any rising edge where valid and ready are both high;
// valid never drops and data never changes while waiting for ready.
module enc_pipe_reg #(
    parameter int           W          = 33,
    parameter logic [W-1:0] RESET_DATA = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    // Accept whenever the slot is empty or is being drained this same cycle.
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= RESET_DATA;
        end else begin
            if (in_ready) begin
                out_valid <= in_valid;
            end
            if (in_valid && in_ready) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: range-checks the immediate, scatters it into the
// format's bit slots and streams the word out through two register stages.
module instr_encoder
    import riscv_enc_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_fmt,
    input  logic [6:0]           in_opcode,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [2:0]           in_funct3,
    input  logic [6:0]           in_funct7,
    input  logic [31:0]          in_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [BEAT_W-1:0]    BEAT_RESET  = {1'b0, NOP};
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

    logic [31:0] packed_word;
    logic        packed_err;
    enc_beat_t   pack_beat;
    enc_beat_t   s1_data;
    enc_beat_t   s2_data;
    logic        s1_valid;
    logic        s2_ready;

    // Out-of-range immediates still pack their truncated low bits; only an
    // illegal format collapses to a NOP.
    always_comb begin
        packed_word = NOP;
        packed_err  = 1'b1;
        case (in_fmt)
            FMT_R: begin
                packed_word = pack_r(in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode);
                packed_err  = 1'b0;
            end
            FMT_I: begin
                packed_word = pack_i(in_imm, in_rs1, in_funct3, in_rd, in_opcode);
                packed_err  = !imm_in_range(in_imm, IMM_I_MIN, IMM_I_MAX);
            end
            FMT_S: begin
                packed_word = pack_s(in_imm, in_rs2, in_rs1, in_funct3, in_opcode);
                packed_err  = !imm_in_range(in_imm, IMM_S_MIN, IMM_S_MAX);
            end
            FMT_B: begin
                packed_word = pack_b(in_imm, in_rs2, in_rs1, in_funct3, in_opcode);
                packed_err  = !imm_in_range(in_imm, IMM_B_MIN, IMM_B_MAX) || in_imm[0];
            end
            FMT_U: begin
                packed_word = pack_u(in_imm, in_rd, in_opcode);
                packed_err  = (in_imm[11:0] != 12'd0);
            end
            FMT_J: begin
                packed_word = pack_j(in_imm, in_rd, in_opcode);
                packed_err  = !imm_in_range(in_imm, IMM_J_MIN, IMM_J_MAX) || in_imm[0];
            end
            default: begin
                packed_word = NOP;
                packed_err  = 1'b1;
            end
        endcase
    end

    assign pack_beat = '{err: packed_err, word: packed_word};

    // The ready chain through both slices is combinational end to end, which
    // lets a simultaneous accept and drain keep the pipe full without a bubble.
    enc_pipe_reg #(
        .W          (BEAT_W),
        .RESET_DATA (BEAT_RESET)
    ) u_s1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (pack_beat),
        .out_valid (s1_valid),
        .out_ready (s2_ready),
        .out_data  (s1_data)
    );

    enc_pipe_reg #(
        .W          (BEAT_W),
        .RESET_DATA (BEAT_RESET)
    ) u_s2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s1_valid),
        .in_ready  (s2_ready),
        .in_data   (s1_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_data)
    );

    assign out_instr = s2_data.word;
    assign out_err   = s2_data.err;

    // Counts errored beats only when they actually leave the encoder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (out_valid && out_ready && out_err && (err_cnt != ERR_CNT_MAX)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule
